data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//   Single-port synchronous data RAM: 64 words x 32 bits (default), one clock domain.
//   Serves as the processor's data memory: word-addressed, chip-enabled, write-enabled.
//   Writes and reads both occur on the rising clock edge; read data is registered.
// PARAMETERS
//   DATA_WIDTH  32               width of each memory word and of dataIn/dataOut
//   ADDR_WIDTH  6                address width in bits; word address, no byte lanes
//   DEPTH       2**ADDR_WIDTH    number of words (64); every address is valid
// PORTS
//   clk      input   1           system clock; all state changes on its rising edge
//   rst      input   1           asynchronous, active-high reset
//   ce       input   1           chip enable; 0 = block idle, no write, dataOut holds
//   we       input   1           write enable; qualified by ce
//   address  input   ADDR_WIDTH  word address for the read or write
//   dataIn   input   DATA_WIDTH  write data
//   dataOut  output  DATA_WIDTH  registered read data
// BEHAVIOUR
//   - One clock (clk). Reset is asynchronous and active-high (rst).
//   - Reset (rst=1, takes effect immediately, independent of clk):
//     dataOut=0 and all DEPTH words cleared to 0. While rst=1, clk edges are ignored.
//   - On rst deassertion, operation resumes at the next rising clk edge.
//   - Rising clk edge, rst=0, decided by ce/we:
//       ce=0          : no memory change; dataOut holds its value.
//       ce=1, we=1    : mem[address] <= dataIn; dataOut holds (no write-through).
//       ce=1, we=0    : dataOut <= mem[address] (read, 1-cycle latency).
//   - Read latency: address sampled at edge N, data visible on dataOut after edge N.
//     dataOut is stable between edges; it never changes combinationally with address.
//   - A read after a write to the same address (any later edge) returns the new data.
//   - we and dataIn are don't-care when ce=0; X/undriven we with ce=0 must not write.
//   - Addresses span the full 0..DEPTH-1 range; no wrap or out-of-range condition.
//   - Unwritten words read as 0 after reset.
//   - Reset mid-operation: an in-progress write on the same edge as rst is discarded.
//   - The memory array is implementable as flip-flops (needed for array reset).
// TESTING
//   1. Reset: rst=1 -> dataOut=0 immediately; then read addr 0..63 with ce=1, we=0
//      -> dataOut=0 for every address.
//   2. Write/read: ce=1, we=1, address=10, dataIn=15 for one edge; then we=0, address=10
//      -> dataOut=15 one edge later; address=0,1,2,3,4 -> dataOut=0 each.
//   3. Chip disable: write 0xDEADBEEF to addr 5 with ce=0 -> a later read of addr 5
//      gives 0; with ce=0, changing the address leaves dataOut unchanged.
//   4. Latency/hold: write 0xA5A5A5A5 to addr 63 and 0x1 to addr 0;
//      alternate reads of 63 and 0 -> dataOut updates only on the edge after each
//      address change. During a write cycle, dataOut keeps the prior read value.
//   5. Async reset mid-run: after writing 0x12345678 to addr 7, pulse rst between
//      edges -> dataOut=0 at once; a read of addr 7 returns 0.
//   6. Overwrite: write 1 then 2 to addr 33 on consecutive edges -> a read returns 2.

Source files
------------

// File: rtl/data_memory.sv
// Single-port synchronous data RAM, word-addressed, with registered read data.
// The array is held in flip-flops so that reset can clear every word.
module data_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ce gates we first, so an undriven we while idle can never write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem     <= '{default: '0};
      dataOut <= '0;
    end else if (ce) begin
      if (we) begin
        mem[address] <= dataIn;
      end else begin
        dataOut <= mem[address];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a vector table of single-edge operations plus
// hand-written sequences for latency, X-qualified write enable and async reset.
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [5:0]  address;
  logic [31:0] dataIn;
  logic [31:0] dataOut;

  int n_tests;
  int n_fail;

  typedef struct {
    logic        ce;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  data_memory #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(6)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .we     (we),
    .address(address),
    .dataIn (dataIn),
    .dataOut(dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic c, logic w, logic [5:0] a, logic [31:0] d, logic [31:0] e);
    vec_t v;
    v.ce   = c;
    v.we   = w;
    v.addr = a;
    v.din  = d;
    v.exp  = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] exp);
    n_tests++;
    if (dataOut !== exp) begin
      n_fail++;
      $display("FAIL %s: dataOut=%h expected=%h at %0t", name, dataOut, exp, $time);
    end
  endtask

  // Drive on the falling edge, return 1 time unit after the next rising edge
  task automatic step(input logic c, input logic w, input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    ce      = c;
    we      = w;
    address = a;
    dataIn  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    ce      = 1'b0;
    we      = 1'b0;
    address = '0;
    dataIn  = '0;
    #1;
    check("reset_dataout", 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Every word reads as zero after reset
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b0, 6'(i), 32'h0);
      check($sformatf("reset_read_%0d", i), 32'h0);
    end

    // Last read was addr 63 (0), so writes below see dataOut hold at 0 initially
    vecs.push_back(mk(1'b1, 1'b1, 6'd10, 32'd15,         32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 6'd10, 32'h0,          32'd15));
    vecs.push_back(mk(1'b1, 1'b0, 6'd0,  32'h0,          32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 6'd1,  32'h0,          32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 6'd2,  32'h0,          32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 6'd3,  32'h0,          32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 6'd4,  32'h0,          32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 6'd5,  32'hDEADBEEF,   32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 6'd5,  32'h0,          32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 6'd10, 32'h0,          32'd15));
    vecs.push_back(mk(1'b0, 1'b0, 6'd20, 32'h0,          32'd15));
    vecs.push_back(mk(1'b0, 1'b0, 6'd0,  32'h0,          32'd15));
    vecs.push_back(mk(1'b1, 1'b1, 6'd63, 32'hA5A5A5A5,   32'd15));
    vecs.push_back(mk(1'b1, 1'b1, 6'd0,  32'h1,          32'd15));
    vecs.push_back(mk(1'b1, 1'b0, 6'd63, 32'h0,          32'hA5A5A5A5));
    vecs.push_back(mk(1'b1, 1'b0, 6'd0,  32'h0,          32'h1));
    vecs.push_back(mk(1'b1, 1'b0, 6'd63, 32'h0,          32'hA5A5A5A5));
    vecs.push_back(mk(1'b1, 1'b1, 6'd1,  32'h77,         32'hA5A5A5A5));
    vecs.push_back(mk(1'b1, 1'b0, 6'd1,  32'h0,          32'h77));
    vecs.push_back(mk(1'b1, 1'b1, 6'd33, 32'h1,          32'h77));
    vecs.push_back(mk(1'b1, 1'b1, 6'd33, 32'h2,          32'h77));
    vecs.push_back(mk(1'b1, 1'b0, 6'd33, 32'h0,          32'h2));

    foreach (vecs[i]) begin
      step(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].din);
      check($sformatf("vec_%0d", i), vecs[i].exp);
    end

    // Address change alone must not move dataOut before the next edge
    step(1'b1, 1'b0, 6'd63, 32'h0);
    check("lat_read63", 32'hA5A5A5A5);
    @(negedge clk);
    address = 6'd0;
    #1;
    check("lat_hold_before_edge", 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    check("lat_after_edge", 32'h1);

    // Idle with an undriven write enable must not write
    @(negedge clk);
    ce      = 1'b0;
    we      = 1'bx;
    address = 6'd2;
    dataIn  = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check("x_we_idle_hold", 32'h1);
    step(1'b1, 1'b0, 6'd2, 32'h0);
    check("x_we_no_write", 32'h0);

    // Asynchronous reset pulse between edges
    step(1'b1, 1'b1, 6'd7, 32'h12345678);
    step(1'b1, 1'b0, 6'd7, 32'h0);
    check("pre_reset_read7", 32'h12345678);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_now", 32'h0);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 6'd7, 32'h0);
    check("post_reset_read7", 32'h0);
    step(1'b1, 1'b0, 6'd10, 32'h0);
    check("post_reset_read10", 32'h0);

    // Write on an edge while reset is held is discarded
    step(1'b1, 1'b1, 6'd9, 32'h9);
    @(negedge clk);
    rst     = 1'b1;
    ce      = 1'b1;
    we      = 1'b1;
    address = 6'd9;
    dataIn  = 32'h55;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 6'd9, 32'h0);
    check("write_during_reset", 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
